ring_counter: RTL and testbench

Free-running WIDTH-bit ring counter (default 4-bit one-hot rotator) that steps one position per clock after a synchronous reset. It provides one-hot sequencing/phase-select for downstream logic and has no handshake, enable or load ports. A compile-time option switches it to a Johnson (twisted-ring) sequence. Another option adds illegal-state self-correction.

---
 rtl/ring_counter_pkg.sv | 47 ++++
 rtl/ring_counter_legal_chk.sv | 26 ++
 rtl/ring_counter.sv | 86 ++++++++
 tb/tb_ring_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ring_counter_pkg.sv
// rtl/ring_counter_pkg.sv - shared constants, default seed and state-validity functions for ring_counter
package ring_counter_pkg;

  // Rotation direction
  localparam bit DIR_LEFT  = 1'b0;
  localparam bit DIR_RIGHT = 1'b1;

  // Sequence type
  localparam bit MODE_RING    = 1'b0;
  localparam bit MODE_JOHNSON = 1'b1;

  // Supported register widths
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

  // Default reset value: only the LSB set, truncated to WIDTH by the caller
  function automatic logic [MAX_WIDTH-1:0] default_seed();
    return {{(MAX_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // True when exactly one of the low 'width' bits is set
  function automatic logic is_one_hot(input logic [MAX_WIDTH-1:0] v, input int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if ((i < width) && v[i]) begin
        cnt = cnt + 1;
      end
    end
    return (cnt == 1);
  endfunction

  // True when the low 'width' bits hold at most one 0/1 boundary between
  // adjacent bits; the MSB-to-LSB wrap is not counted. Exactly 2*width codes
  // satisfy this, matching the Johnson sequence.
  function automatic logic is_johnson(input logic [MAX_WIDTH-1:0] v, input int width);
    int edges;
    edges = 0;
    for (int i = 0; i < MAX_WIDTH - 1; i++) begin
      if ((i + 1 < width) && (v[i] != v[i+1])) begin
        edges = edges + 1;
      end
    end
    return (edges <= 1);
  endfunction

endpackage

// File: rtl/ring_counter_legal_chk.sv
// rtl/ring_counter_legal_chk.sv - combinational legality check of a ring or Johnson counter state
module ring_counter_legal_chk
  import ring_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_state,
  input  logic             i_mode,
  output logic             o_legal
);

  logic [MAX_WIDTH-1:0] w_state_ext;

  assign w_state_ext = MAX_WIDTH'(i_state);

  // Ring states must be one-hot; Johnson states must be a single run boundary
  always_comb begin
    o_legal = 1'b0;
    if (i_mode == MODE_JOHNSON) begin
      o_legal = is_johnson(w_state_ext, WIDTH);
    end else begin
      o_legal = is_one_hot(w_state_ext, WIDTH);
    end
  end

endmodule

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - free-running ring/Johnson counter; RING_COUNTER_SELF_CORRECT_EN adds illegal-state recovery
module ring_counter
  import ring_counter_pkg::*;
#(
  parameter int             WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(default_seed()),
  parameter bit             DIR   = DIR_LEFT,
  parameter bit             MODE  = MODE_RING
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] dout
);

  if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("ring_counter: WIDTH must be in 2..32");
  end

  logic [WIDTH-1:0] r_dout;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_next;
  logic             w_fb_left;
  logic             w_fb_right;

  // Bit re-entering at the far end: copied in ring mode, inverted in Johnson mode
  always_comb begin
    w_fb_left  = r_dout[WIDTH-1];
    w_fb_right = r_dout[0];
    if (MODE == MODE_JOHNSON) begin
      w_fb_left  = ~r_dout[WIDTH-1];
      w_fb_right = ~r_dout[0];
    end
  end

  // One-position shift in the configured direction
  always_comb begin
    w_rot = r_dout;
    if (DIR == DIR_LEFT) begin
      w_rot = {r_dout[WIDTH-2:0], w_fb_left};
    end else begin
      w_rot = {w_fb_right, r_dout[WIDTH-1:1]};
    end
  end

`ifdef RING_COUNTER_SELF_CORRECT_EN
  logic w_legal;

  if (((MODE == MODE_RING) && !is_one_hot(MAX_WIDTH'(SEED), WIDTH)) ||
      ((MODE == MODE_JOHNSON) && !is_johnson(MAX_WIDTH'(SEED), WIDTH))) begin : g_bad_seed
    $error("ring_counter: SEED is not a legal state for the selected MODE");
  end

  ring_counter_legal_chk #(
    .WIDTH (WIDTH)
  ) u_legal_chk (
    .i_state (r_dout),
    .i_mode  (MODE),
    .o_legal (w_legal)
  );

  // A corrupted state is replaced by SEED instead of being rotated onward
  always_comb begin
    w_next = SEED;
    if (w_legal) begin
      w_next = w_rot;
    end
  end
`else
  // Pure rotation: whatever pattern is present keeps circulating
  always_comb begin
    w_next = w_rot;
  end
`endif

  // State register; reset has priority over stepping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= SEED;
    end else begin
      r_dout <= w_next;
    end
  end

  assign dout = r_dout;

endmodule

// File: tb/tb_ring_counter.sv
// tb/tb_ring_counter.sv - scoreboard bench for ring_counter across ring/Johnson, both directions and widths
module tb_ring_counter;

`ifdef RING_COUNTER_SELF_CORRECT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] dout_a;
  logic [3:0] dout_b;
  logic [3:0] dout_c;
  logic [3:0] dout_e;
  logic [7:0] dout_d;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [3:0] e;
    logic [7:0] d;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  int   vec;

  // A: defaults (ring, left, 4 bits, seed 0001)
  ring_counter u_a (.clk(clk), .rst(rst), .dout(dout_a));
  // B: ring, right
  ring_counter #(.DIR(1'b1)) u_b (.clk(clk), .rst(rst), .dout(dout_b));
  // C: Johnson, left
  ring_counter #(.MODE(1'b1)) u_c (.clk(clk), .rst(rst), .dout(dout_c));
  // D: 8-bit ring with custom seed
  ring_counter #(.WIDTH(8), .SEED(8'h10)) u_d (.clk(clk), .rst(rst), .dout(dout_d));
  // E: Johnson, right
  ring_counter #(.MODE(1'b1), .DIR(1'b1)) u_e (.clk(clk), .rst(rst), .dout(dout_e));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, act, exp);
    end
  endtask

  // Drive one edge's inputs (plus optional corruption), queue what the edge must produce
  task automatic step(input logic r, input int frc,
                      input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec,
                      input logic [7:0] ed, input logic [3:0] ee);
    exp_t e;
    rst = r;
    if (frc == 1) begin
      force u_a.r_dout = 4'b0110;
      #1;
      release u_a.r_dout;
    end
    if (frc == 2) begin
      force u_b.r_dout = 4'b0000;
      force u_c.r_dout = 4'b0101;
      #1;
      release u_b.r_dout;
      release u_c.r_dout;
    end
    e.a = ea; e.b = eb; e.c = ec; e.d = ed; e.e = ee; e.idx = vec;
    q.push_back(e);
    vec = vec + 1;
    @(negedge clk);
  endtask

  // Monitor: after every rising edge compare all outputs against the next queued entry
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ring_left",     e.idx, {4'h0, dout_a}, {4'h0, e.a});
        chk("ring_right",    e.idx, {4'h0, dout_b}, {4'h0, e.b});
        chk("johnson_left",  e.idx, {4'h0, dout_c}, {4'h0, e.c});
        chk("ring_w8_seed",  e.idx, dout_d,         e.d);
        chk("johnson_right", e.idx, {4'h0, dout_e}, {4'h0, e.e});
      end
    end
  end

  initial begin
    int budget;
    checks   = 0;
    failures = 0;
    vec      = 0;
    rst      = 1'b1;
    //    rst  frc  A        B        C        D       E
    step(1'b1, 0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 4'b0001);
    step(1'b1, 0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 4'b0001);
    step(1'b0, 0, 4'b0010, 4'b1000, 4'b0011, 8'h20, 4'b0000);
    step(1'b0, 0, 4'b0100, 4'b0100, 4'b0111, 8'h40, 4'b1000);
    step(1'b0, 0, 4'b1000, 4'b0010, 4'b1111, 8'h80, 4'b1100);
    step(1'b0, 0, 4'b0001, 4'b0001, 4'b1110, 8'h01, 4'b1110);
    step(1'b0, 0, 4'b0010, 4'b1000, 4'b1100, 8'h02, 4'b1111);
    step(1'b0, 0, 4'b0100, 4'b0100, 4'b1000, 8'h04, 4'b0111);
    step(1'b0, 0, 4'b1000, 4'b0010, 4'b0000, 8'h08, 4'b0011);
    step(1'b0, 0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 4'b0001);
    step(1'b0, 0, 4'b0010, 4'b1000, 4'b0011, 8'h20, 4'b0000);
    step(1'b0, 0, 4'b0100, 4'b0100, 4'b0111, 8'h40, 4'b1000);
    // mid-sequence reset pulse while A=0100
    step(1'b1, 0, 4'b0001, 4'b0001, 4'b0001, 8'h10, 4'b0001);
    step(1'b0, 0, 4'b0010, 4'b1000, 4'b0011, 8'h20, 4'b0000);
    step(1'b0, 0, 4'b0100, 4'b0100, 4'b0111, 8'h40, 4'b1000);
    // A corrupted to 0110 (not one-hot)
    step(1'b0, 1, SC ? 4'b0001 : 4'b1100, 4'b0010, 4'b1111, 8'h80, 4'b1100);
    step(1'b0, 0, SC ? 4'b0010 : 4'b1001, 4'b0001, 4'b1110, 8'h01, 4'b1110);
    step(1'b0, 0, SC ? 4'b0100 : 4'b0011, 4'b1000, 4'b1100, 8'h02, 4'b1111);
    // B corrupted to 0000, C corrupted to 0101 (two run boundaries)
    step(1'b0, 2, SC ? 4'b1000 : 4'b0110, SC ? 4'b0001 : 4'b0000,
         SC ? 4'b0001 : 4'b1011, 8'h04, 4'b0111);
    step(1'b0, 0, SC ? 4'b0001 : 4'b1100, SC ? 4'b1000 : 4'b0000,
         SC ? 4'b0011 : 4'b0110, 8'h08, 4'b0011);
    step(1'b0, 0, SC ? 4'b0010 : 4'b1001, SC ? 4'b0100 : 4'b0000,
         SC ? 4'b0111 : 4'b1101, 8'h10, 4'b0001);

    budget = 0;
    while ((q.size() > 0) && (budget < 20)) begin
      @(negedge clk);
      budget = budget + 1;
    end
    if (q.size() > 0) begin
      checks   = checks + 1;
      failures = failures + 1;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
